// File: rtl/gpio_pkg.sv
// Shared definitions for the GPIO input port: register offsets, default window base
// and the debounce counter sizing helper.
package gpio_pkg;

    localparam logic [1:0] GPIO_IN_DATA  = 2'd0;
    localparam logic [1:0] GPIO_IN_RISE  = 2'd1;
    localparam logic [1:0] GPIO_IN_FALL  = 2'd2;
    localparam logic [1:0] GPIO_IN_IRQEN = 2'd3;

    localparam logic [31:0] GPIO_BASE_ADDR = 32'h0000_0100;

    // Counter must hold DEBOUNCE_CYCLES-1; never narrower than one bit.
    function automatic int cnt_width(input int cycles);
        return (cycles > 1) ? $clog2(cycles) : 1;
    endfunction

endpackage

// File: rtl/gpio_debounce_bit.sv
// One input pin: two-flop synchroniser, persistence counter and accepted level,
// with single-cycle rise/fall strobes on the edge where the accepted level changes.
module gpio_debounce_bit
    import gpio_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic pin,
    output logic stable,
    output logic rise,
    output logic fall
);

    localparam int CW = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

    logic          s1_reg;
    logic          s2_reg;
    logic          stable_reg;
    logic [CW-1:0] cnt_reg;
    logic          accept;

    // The synchronised level has differed from the accepted one long enough.
    assign accept = (s2_reg != stable_reg) && (cnt_reg == CNT_MAX);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_reg     <= 1'b0;
            s2_reg     <= 1'b0;
            stable_reg <= 1'b0;
            cnt_reg    <= '0;
        end else begin
            s1_reg <= pin;
            s2_reg <= s1_reg;
            if (s2_reg == stable_reg) begin
                cnt_reg <= '0;
            end else if (accept) begin
                stable_reg <= s2_reg;
                cnt_reg    <= '0;
            end else begin
                cnt_reg <= cnt_reg + CW'(1);
            end
        end
    end

    assign stable = stable_reg;
    assign rise   = accept & s2_reg;
    assign fall   = accept & ~s2_reg;

endmodule

// File: rtl/gpio_in_ctrl.sv
// Memory-mapped GPIO input port: per-pin debouncers, sticky W1C edge flags,
// interrupt enable register, combinational read mux and level interrupt.
module gpio_in_ctrl
    import gpio_pkg::*;
#(
    parameter int          WIDTH           = 32,
    parameter int          DEBOUNCE_CYCLES = 16,
    parameter logic [31:0] BASE_ADDR       = GPIO_BASE_ADDR
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] pin_in,
    input  logic [31:0]      Address,
    input  logic [31:0]      Wdata,
    input  logic             MemW,
    output logic             sel,
    output logic [31:0]      Rdata,
    output logic             irq
);

    logic [WIDTH-1:0] data_stable;
    logic [WIDTH-1:0] rise_pulse;
    logic [WIDTH-1:0] fall_pulse;
    logic [WIDTH-1:0] rise_reg;
    logic [WIDTH-1:0] fall_reg;
    logic [WIDTH-1:0] irq_en_reg;
    logic [WIDTH-1:0] rise_clr;
    logic [WIDTH-1:0] fall_clr;
    logic [1:0]       offset;
    logic             wr_en;
    logic             unused_bits;

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_bit
            gpio_debounce_bit #(
                .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
            ) u_bit (
                .clk   (clk),
                .rst   (rst),
                .pin   (pin_in[gi]),
                .stable(data_stable[gi]),
                .rise  (rise_pulse[gi]),
                .fall  (fall_pulse[gi])
            );
        end
    endgenerate

    assign sel    = (Address[31:4] == BASE_ADDR[31:4]);
    assign offset = Address[3:2];
    assign wr_en  = MemW & sel;

    // Byte lane bits and store data above WIDTH play no part in the register file.
    assign unused_bits = ^{Address[1:0], Wdata};

    assign rise_clr = (wr_en && offset == GPIO_IN_RISE) ? Wdata[WIDTH-1:0] : '0;
    assign fall_clr = (wr_en && offset == GPIO_IN_FALL) ? Wdata[WIDTH-1:0] : '0;

    // New edges are OR-ed in after the clear so a same-cycle set survives.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rise_reg   <= '0;
            fall_reg   <= '0;
            irq_en_reg <= '0;
        end else begin
            rise_reg <= (rise_reg & ~rise_clr) | rise_pulse;
            fall_reg <= (fall_reg & ~fall_clr) | fall_pulse;
            if (wr_en && offset == GPIO_IN_IRQEN) begin
                irq_en_reg <= Wdata[WIDTH-1:0];
            end
        end
    end

    always_comb begin
        Rdata = '0;
        if (sel) begin
            case (offset)
                GPIO_IN_DATA:  Rdata[WIDTH-1:0] = data_stable;
                GPIO_IN_RISE:  Rdata[WIDTH-1:0] = rise_reg;
                GPIO_IN_FALL:  Rdata[WIDTH-1:0] = fall_reg;
                default:       Rdata[WIDTH-1:0] = irq_en_reg;
            endcase
        end
    end

    assign irq = |((rise_reg | fall_reg) & irq_en_reg);

endmodule

// File: tb/tb_gpio_in_ctrl.sv
// Self-checking bench for gpio_in_ctrl (WIDTH=8, DEBOUNCE_CYCLES=4, base 0x100),
// scoreboard of expected register/irq/sel values drained after each stimulus step.
module tb_gpio_in_ctrl;

    localparam int K_RD  = 0;
    localparam int K_IRQ = 1;
    localparam int K_SEL = 2;

    localparam logic [31:0] A_DATA = 32'h100;
    localparam logic [31:0] A_RISE = 32'h104;
    localparam logic [31:0] A_FALL = 32'h108;
    localparam logic [31:0] A_IEN  = 32'h10C;

    logic        clk;
    logic        rst;
    logic [7:0]  pin_in;
    logic [31:0] Address;
    logic [31:0] Wdata;
    logic        MemW;
    logic        sel;
    logic [31:0] Rdata;
    logic        irq;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        string       tag;
        int          kind;
        logic [31:0] addr;
        logic [31:0] exp;
    } sb_t;

    sb_t sb_q[$];

    gpio_in_ctrl #(
        .WIDTH          (8),
        .DEBOUNCE_CYCLES(4),
        .BASE_ADDR      (32'h0000_0100)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .pin_in (pin_in),
        .Address(Address),
        .Wdata  (Wdata),
        .MemW   (MemW),
        .sel    (sel),
        .Rdata  (Rdata),
        .irq    (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end else begin
            $display("ok   %s: 0x%08h", tag, got);
        end
    endtask

    task automatic sb_push(input string tag, input int kind, input logic [31:0] addr,
                           input logic [31:0] exp);
        sb_t e;
        e.tag  = tag;
        e.kind = kind;
        e.addr = addr;
        e.exp  = exp;
        sb_q.push_back(e);
    endtask

    task automatic sb_drain();
        sb_t         e;
        logic [31:0] got;
        while (sb_q.size() > 0) begin
            e       = sb_q.pop_front();
            Address = e.addr;
            #1;
            case (e.kind)
                K_RD:    got = Rdata;
                K_IRQ:   got = {31'b0, irq};
                default: got = {31'b0, sel};
            endcase
            check(e.tag, got, e.exp);
        end
    endtask

    task automatic expect_rd(input string tag, input logic [31:0] addr, input logic [31:0] exp);
        sb_push(tag, K_RD, addr, exp);
        sb_drain();
    endtask

    task automatic expect_irq(input string tag, input logic exp);
        sb_push(tag, K_IRQ, A_DATA, {31'b0, exp});
        sb_drain();
    endtask

    // Called at a falling edge; the store lands on the following rising edge.
    task automatic bus_write(input logic [31:0] addr, input logic [31:0] data);
        Address = addr;
        Wdata   = data;
        MemW    = 1'b1;
        @(negedge clk);
        MemW  = 1'b0;
        Wdata = '0;
    endtask

    initial begin
        rst     = 1'b0;
        pin_in  = '0;
        Address = A_DATA;
        Wdata   = '0;
        MemW    = 1'b0;

        // Reset state and address decode
        repeat (2) @(negedge clk);
        expect_rd("rst_data_in_reset", A_DATA, 32'h0);
        rst = 1'b1;
        @(negedge clk);
        expect_rd("rst_data", A_DATA, 32'h0);
        expect_rd("rst_rise", A_RISE, 32'h0);
        expect_rd("rst_fall", A_FALL, 32'h0);
        expect_rd("rst_ien",  A_IEN,  32'h0);
        expect_irq("rst_irq", 1'b0);
        sb_push("sel_100", K_SEL, 32'h100, 32'h1);
        sb_push("sel_10f", K_SEL, 32'h10F, 32'h1);
        sb_push("sel_0ff", K_SEL, 32'h0FF, 32'h0);
        sb_push("sel_110", K_SEL, 32'h110, 32'h0);
        sb_drain();
        expect_rd("rd_110", 32'h110, 32'h0);

        // Debounced rising edge with irq enabled
        bus_write(A_IEN, 32'h01);
        expect_rd("ien_wr", A_IEN, 32'h01);
        pin_in = 8'h01;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            sb_push($sformatf("deb_data_e%0d", k), K_RD, A_DATA, (k == 6) ? 32'h01 : 32'h00);
            sb_push($sformatf("deb_irq_e%0d", k), K_IRQ, A_DATA, (k == 6) ? 32'h1 : 32'h0);
            sb_drain();
        end
        expect_rd("deb_rise", A_RISE, 32'h01);
        expect_rd("deb_fall", A_FALL, 32'h00);

        // Short pulse on pin 3 is rejected
        pin_in = 8'h09;
        repeat (3) @(negedge clk);
        pin_in = 8'h01;
        repeat (10) @(negedge clk);
        expect_rd("glitch_data", A_DATA, 32'h01);
        expect_rd("glitch_rise", A_RISE, 32'h01);
        expect_rd("glitch_fall", A_FALL, 32'h00);

        // Write-1-to-clear, read-only DATA, IRQ_EN width, falling edge
        pin_in = 8'h05;
        repeat (8) @(negedge clk);
        expect_rd("w1c_pre_data", A_DATA, 32'h05);
        expect_rd("w1c_pre_rise", A_RISE, 32'h05);
        bus_write(A_RISE, 32'h04);
        expect_rd("w1c_rise_a", A_RISE, 32'h01);
        expect_irq("w1c_irq_a", 1'b1);
        bus_write(A_RISE, 32'h01);
        expect_rd("w1c_rise_b", A_RISE, 32'h00);
        expect_irq("w1c_irq_b", 1'b0);
        bus_write(A_DATA, 32'hFF);
        expect_rd("data_ro", A_DATA, 32'h05);
        bus_write(A_IEN, 32'hFFFF_FFFF);
        expect_rd("ien_upper", A_IEN, 32'h0000_00FF);
        bus_write(A_IEN, 32'h01);
        pin_in = 8'h04;
        repeat (8) @(negedge clk);
        expect_rd("fall_data", A_DATA, 32'h04);
        expect_rd("fall_flag", A_FALL, 32'h01);
        expect_irq("fall_irq", 1'b1);
        bus_write(A_IEN, 32'h00);
        expect_irq("ien_off_irq", 1'b0);
        bus_write(A_FALL, 32'hFF);
        expect_rd("fall_clr", A_FALL, 32'h00);
        bus_write(32'h11C, 32'hFF);
        expect_rd("wr_outside", A_IEN, 32'h00);

        // Set and clear of RISE[1] on the same edge: set wins
        pin_in = 8'h06;
        repeat (5) @(negedge clk);
        bus_write(A_RISE, 32'h02);
        expect_rd("coll_data", A_DATA, 32'h06);
        expect_rd("coll_rise", A_RISE, 32'h02);
        bus_write(A_RISE, 32'h02);
        expect_rd("coll_clr", A_RISE, 32'h00);

        // Reset part-way through a debounce
        pin_in = 8'h80;
        repeat (4) @(negedge clk);
        expect_rd("mid_pre_data", A_DATA, 32'h06);
        Address = A_DATA;
        rst     = 1'b0;
        #1;
        check("mid_rst_data", Rdata, 32'h0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            sb_push($sformatf("rel_data_e%0d", k), K_RD, A_DATA, (k == 6) ? 32'h80 : 32'h00);
            sb_push($sformatf("rel_rise_e%0d", k), K_RD, A_RISE, (k == 6) ? 32'h80 : 32'h00);
            sb_drain();
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
